// File: rtl/control_unit_pipe.sv
// Control unit for the 4-bit-opcode RISC core: opcode decode into the ID/EX
// control register plus a hazard/sequencing FSM (mul/div stalls, load-use, flush).
module control_unit_pipe #(
    parameter int RW          = 4,
    parameter int MUL_CYCLES  = 3,
    parameter int DIV_CYCLES  = 8,
    parameter int FLUSH_SLOTS = 1,
    parameter int CNTW        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    opcode,
    input  logic          B_taken,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_ld_valid,
    output logic          pc_src,
    output logic          rr1_src,
    output logic          rr2_src,
    output logic          wr_src,
    output logic          format_sel,
    output logic [9:0]    c_dec_in,
    output logic          flush_ir,
    output logic          stall_n,
    output logic          bank_en,
    output logic          busy
);

    typedef enum logic [1:0] {S_RUN, S_MDIV, S_FLUSH} state_t;

    localparam logic [3:0] OP_SHR = 4'h3;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_ADI = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_LD  = 4'hA;
    localparam logic [3:0] OP_DIV = 4'hB;
    localparam logic [3:0] OP_LUI = 4'hC;
    localparam logic [3:0] OP_BEQ = 4'hD;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_JAL = 4'hF;
    localparam logic [9:0] BUBBLE = 10'h000;

    state_t          state, state_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic [9:0]      word_nxt;
    logic            bank_pending, bank_nxt;
    logic            is_rfmt, uses_rs2, is_jump, taken, hz;

    // Control word: [0] imm, [4:1] aluop, [5] mem wr, [6] mem rd,
    // [7] reg wr, [8] wb-from-mem, [9] bank/shift flag.
    function automatic logic [9:0] decode(input logic [3:0] op);
        logic [9:0] w;
        w = BUBBLE;
        case (op)
            OP_ADI:  begin w[0] = 1'b1; w[7] = 1'b1; w[9] = 1'b1; end
            OP_ST:   begin w[0] = 1'b1; w[5] = 1'b1; end
            OP_LD:   begin w[0] = 1'b1; w[6] = 1'b1; w[7] = 1'b1; w[8] = 1'b1; w[9] = 1'b1; end
            OP_LUI:  begin w[0] = 1'b1; w[4:1] = 4'b1100; w[7] = 1'b1; end
            OP_BEQ:  w[4:1] = 4'b1111;
            OP_JMP, OP_JAL: w = BUBBLE;
            default: begin w[4:1] = op; w[7] = 1'b1; w[9] = (op == OP_SHR); end
        endcase
        return w;
    endfunction

    assign is_rfmt  = (opcode <= 4'h7) || (opcode == OP_DIV);
    assign uses_rs2 = is_rfmt || (opcode == OP_ST) || (opcode == OP_BEQ);
    assign is_jump  = (opcode == OP_JMP) || (opcode == OP_JAL);
    assign taken    = is_jump || ((opcode == OP_BEQ) && B_taken);
    assign hz       = (state == S_RUN) && ex_ld_valid && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || ((ex_rd == id_rs2) && uses_rs2));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; comb blocks below use blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_RUN;
            cnt          <= '0;
            c_dec_in     <= BUBBLE;
            bank_pending <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            c_dec_in     <= word_nxt;
            bank_pending <= bank_nxt;
        end
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = BUBBLE;
        bank_nxt  = bank_pending;
        case (state)
            S_RUN: begin
                if (!hz) begin
                    word_nxt = decode(opcode);
                    bank_nxt = (opcode == OP_SHR);
                    if (taken) begin
                        if (FLUSH_SLOTS > 1) begin
                            state_nxt = S_FLUSH;
                            cnt_nxt   = CNTW'(FLUSH_SLOTS - 1);
                        end
                    end else if ((opcode == OP_MUL) && (MUL_CYCLES > 1)) begin
                        state_nxt = S_MDIV;
                        cnt_nxt   = CNTW'(MUL_CYCLES - 1);
                    end else if ((opcode == OP_DIV) && (DIV_CYCLES > 1)) begin
                        state_nxt = S_MDIV;
                        cnt_nxt   = CNTW'(DIV_CYCLES - 1);
                    end
                end
            end
            S_MDIV, S_FLUSH: begin
                if (cnt == CNTW'(1)) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNTW'(1);
                end
            end
            default: begin
                state_nxt = S_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Side signals fall back to R-format values whenever nothing is issuing.
    always_comb begin
        pc_src     = 1'b0;
        rr1_src    = 1'b1;
        rr2_src    = 1'b1;
        wr_src     = 1'b0;
        format_sel = 1'b0;
        flush_ir   = (state == S_FLUSH);
        stall_n    = !((state == S_MDIV) || hz);
        if ((state == S_RUN) && !hz) begin
            rr1_src    = is_rfmt || is_jump;
            rr2_src    = is_rfmt || is_jump;
            wr_src     = (opcode == OP_ADI) || (opcode == OP_ST) || (opcode == OP_LD) ||
                         (opcode == OP_LUI) || (opcode == OP_BEQ);
            format_sel = is_jump;
            pc_src     = taken;
            flush_ir   = taken;
        end
    end

    assign bank_en = bank_pending && opcode[3] && (opcode[2:1] != 2'b11) && (state == S_RUN);
    assign busy    = (state != S_RUN);

endmodule

// File: tb/tb_control_unit_pipe.sv
// Scoreboard bench for control_unit_pipe: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares against the DUT.
module tb_control_unit_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       B_taken = 1'b0;
    logic [3:0] id_rs1 = 4'd1;
    logic [3:0] id_rs2 = 4'd2;
    logic [3:0] ex_rd = 4'd0;
    logic       ex_ld_valid = 1'b0;
    logic       pc_src, rr1_src, rr2_src, wr_src, format_sel;
    logic [9:0] c_dec_in;
    logic       flush_ir, stall_n, bank_en, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [9:0]  dec;
        logic [8:0]  flags;
    } exp_t;
    exp_t sb[$];

    // flags = {pc_src, rr1, rr2, wr, format, flush_ir, stall_n, bank_en, busy}
    localparam logic [8:0] F_R    = 9'b0_1_1_0_0_0_1_0_0;
    localparam logic [8:0] F_I    = 9'b0_0_0_1_0_0_1_0_0;
    localparam logic [8:0] F_HZ   = 9'b0_1_1_0_0_0_0_0_0;
    localparam logic [8:0] F_MDIV = 9'b0_1_1_0_0_0_0_0_1;
    localparam logic [8:0] F_FL   = 9'b0_1_1_0_0_1_1_0_1;
    localparam logic [8:0] F_BANK = 9'b0_0_0_0_0_0_0_1_0;

    control_unit_pipe #(
        .RW(4), .MUL_CYCLES(3), .DIV_CYCLES(8), .FLUSH_SLOTS(3), .CNTW(4)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .B_taken(B_taken),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_ld_valid(ex_ld_valid),
        .pc_src(pc_src), .rr1_src(rr1_src), .rr2_src(rr2_src), .wr_src(wr_src),
        .format_sel(format_sel), .c_dec_in(c_dec_in), .flush_ir(flush_ir),
        .stall_n(stall_n), .bank_en(bank_en), .busy(busy)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus; dec is the c_dec_in value held during this cycle.
    task automatic v(input string name, input logic r, input logic [3:0] op, input logic bt,
                     input logic [3:0] rd, input logic ld, input logic [3:0] rs2,
                     input logic [9:0] dec, input logic [8:0] flags);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        opcode      = op;
        B_taken     = bt;
        ex_rd       = rd;
        ex_ld_valid = ld;
        id_rs2      = rs2;
        id_rs1      = 4'd1;
        e.name  = name;
        e.dec   = dec;
        e.flags = flags;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {pc_src, rr1_src, rr2_src, wr_src, format_sel,
                       flush_ir, stall_n, bank_en, busy};
                checks++;
                if (c_dec_in !== e.dec || act !== e.flags) begin
                    errors++;
                    $display("FAIL %s: got c_dec=%03h flags=%09b, expected c_dec=%03h flags=%09b",
                             e.name, c_dec_in, act, e.dec, e.flags);
                end
            end
        end
    end

    initial begin : driver
        int waited;
        //  name          rst op    bt rd  ld rs2   dec     flags
        v("reset",        0, 4'h0, 0, 0, 0, 2, 10'h000, F_R);
        v("add",          1, 4'h0, 0, 0, 0, 2, 10'h000, F_R);
        v("ld_use_hz",    1, 4'h0, 0, 3, 1, 3, 10'h080, F_HZ);
        v("ld_rd0_nohz",  1, 4'h0, 0, 0, 1, 0, 10'h000, F_R);
        v("div_issue",    1, 4'hB, 0, 0, 0, 2, 10'h080, F_R);
        v("div_st1",      1, 4'hE, 0, 0, 0, 2, 10'h096, F_MDIV);
        v("div_st2",      1, 4'hE, 0, 0, 0, 2, 10'h000, F_MDIV);
        v("div_st3",      1, 4'hE, 0, 0, 0, 2, 10'h000, F_MDIV);
        v("div_st4",      1, 4'hE, 0, 0, 0, 2, 10'h000, F_MDIV);
        v("div_st5",      1, 4'hE, 0, 0, 0, 2, 10'h000, F_MDIV);
        v("div_st6",      1, 4'hE, 0, 0, 0, 2, 10'h000, F_MDIV);
        v("div_st7",      1, 4'hE, 0, 0, 0, 2, 10'h000, F_MDIV);
        v("div_done",     1, 4'h0, 0, 0, 0, 2, 10'h000, F_R);
        v("div2_issue",   1, 4'hB, 0, 0, 0, 2, 10'h080, F_R);
        v("div2_st1",     1, 4'h0, 0, 0, 0, 2, 10'h096, F_MDIV);
        v("div2_st2",     1, 4'h0, 0, 0, 0, 2, 10'h000, F_MDIV);
        v("rst_mid_mdiv", 0, 4'h0, 0, 0, 0, 2, 10'h000, F_R);
        v("post_reset",   1, 4'h0, 0, 0, 0, 2, 10'h000, F_R);
        v("beq_taken",    1, 4'hD, 1, 0, 0, 2, 10'h080, 9'b1_0_0_1_0_1_1_0_0);
        v("flush1",       1, 4'h0, 0, 0, 0, 2, 10'h01E, F_FL);
        v("flush2",       1, 4'h0, 0, 0, 0, 2, 10'h000, F_FL);
        v("beq_not",      1, 4'hD, 0, 0, 0, 2, 10'h000, F_I);
        v("shr",          1, 4'h3, 0, 0, 0, 2, 10'h01E, F_R);
        v("adi_hz",       1, 4'h8, 0, 1, 1, 2, 10'h286, F_HZ | F_BANK);
        v("adi_bank",     1, 4'h8, 0, 0, 0, 2, 10'h000, F_I | F_BANK);
        v("lui_nobank",   1, 4'hC, 0, 0, 0, 2, 10'h281, F_I);
        v("shr2",         1, 4'h3, 0, 0, 0, 2, 10'h099, F_R);
        v("add_clear",    1, 4'h0, 0, 0, 0, 2, 10'h286, F_R);
        v("adi_nobank",   1, 4'h8, 0, 0, 0, 2, 10'h080, F_I);
        v("jal_hz",       1, 4'hF, 0, 1, 1, 2, 10'h281, F_HZ);
        v("jal_taken",    1, 4'hF, 0, 0, 0, 2, 10'h000, 9'b1_1_1_0_1_1_1_0_0);
        v("jal_flush1",   1, 4'h0, 0, 0, 0, 2, 10'h000, F_FL);
        v("jal_flush2",   1, 4'h0, 0, 0, 0, 2, 10'h000, F_FL);
        v("mul_issue",    1, 4'h2, 0, 0, 0, 2, 10'h000, F_R);
        v("mul_st1",      1, 4'h0, 0, 0, 0, 2, 10'h084, F_MDIV);
        v("mul_st2",      1, 4'h0, 0, 0, 0, 2, 10'h000, F_MDIV);
        v("st_rs2_hz",    1, 4'h9, 0, 2, 1, 2, 10'h000, F_HZ);
        v("adi_rs2_nohz", 1, 4'h8, 0, 2, 1, 2, 10'h000, F_I);
        v("add_after",    1, 4'h0, 0, 0, 0, 2, 10'h281, F_R);
        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit_pipe.md
Name: control_unit_pipe

Overview:
- Next-generation control unit for the 4-bit-opcode RISC core.
- Decodes the ID-stage opcode and registers the control word into the ID/EX control register (c_dec_in).
- Adds a hazard/sequencing FSM:
  - multi-cycle stalls for mul/div, with parametrised latency;
  - load-use interlock;
  - parametrised branch/jump flush depth;
  - sticky bank-select after shr.

Parameters:
- RW, 4, register-index width.
- MUL_CYCLES, 3, mul execute cycles; the front end stalls MUL_CYCLES-1 cycles.
- DIV_CYCLES, 8, div execute cycles; the front end stalls DIV_CYCLES-1 cycles.
- FLUSH_SLOTS, 1, bubble slots after a taken beq/jmp/jal (>=1).
- CNTW, 4, counter width; must hold max(MUL_CYCLES, DIV_CYCLES, FLUSH_SLOTS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  4  ID-stage opcode.
- B_taken  in  1  beq condition true.
- id_rs1  in  RW  ID source 1 index.
- id_rs2  in  RW  ID source 2 index.
- ex_rd  in  RW  EX-stage destination index.
- ex_ld_valid  in  1  EX stage holds a ld.
- pc_src  out  1  select branch/jump target (combinational).
- rr1_src  out  1  read-reg-1 source select (combinational).
- rr2_src  out  1  read-reg-2 source select (combinational).
- wr_src  out  1  write-reg select (combinational).
- format_sel  out  1  J-format select (combinational).
- c_dec_in  out  10  registered ID/EX control word.
- flush_ir  out  1  flush IF/ID register.
- stall_n  out  1  active-low front-end stall (PC/IR hold).
- bank_en  out  1  alternate register bank for the current I-format instruction.
- busy  out  1  FSM not in RUN.

Behaviour:
- Opcodes: add 0, sub 1, mul 2, shr 3, slt 4, xor 5, or 6, and 7, adi 8, st 9, ld A, div B, lui C, beq D, jmp E, jal F.
- Control word bits: [0] imm, [4:1] aluop, [5] mem wr, [6] mem rd, [7] reg wr, [8] wb-from-mem, [9] bank/shift flag.
  - R-format (0-7, B): [4:1]=opcode, [7]=1, [9]=1 only for shr; all other bits 0.
  - adi: [0]=1, [7]=1, [9]=1.
  - st: [0]=1, [5]=1.
  - ld: [0]=1, [6]=1, [7]=1, [8]=1, [9]=1.
  - lui: [0]=1, [4:1]=1100, [7]=1.
  - beq: [4:1]=1111.
  - jmp, jal: all 0.
  - Bubble: all 0.
- Combinational side signals, valid in RUN and no hazard; otherwise rr*/wr/format at R-format values and pc_src=0:
  - rr1_src=rr2_src=1 for R-format, jmp, jal; 0 for the other opcodes.
  - wr_src=1 for 8, 9, A, C, D.
  - format_sel=1 for E, F.
  - pc_src=1 for E, F, and D when B_taken.
- Load-use hazard, evaluated in RUN only:
  - hz = ex_ld_valid && ex_rd != 0 && (ex_rd == id_rs1 || (ex_rd == id_rs2 && opcode is R-format, st or beq)).
  - hz forces stall_n=0, pc_src=0, flush_ir=0.
  - Next edge: c_dec_in <= bubble; state stays RUN.
- FSM states RUN, MDIV, FLUSH, with a counter cnt. Priority in RUN: hz > taken beq/jmp/jal > mul/div > normal.
- RUN, normal: c_dec_in <= decoded word; stall_n=1; flush_ir=0.
- RUN, taken beq/jmp/jal: flush_ir=1 combinational; c_dec_in <= its word.
  - If FLUSH_SLOTS > 1: go to FLUSH with cnt <= FLUSH_SLOTS-1.
- FLUSH: flush_ir=1, stall_n=1, c_dec_in <= bubble; cnt decrements each edge; go to RUN on the edge where cnt==1.
- RUN, mul/div: c_dec_in <= its word.
  - If the latency L > 1: go to MDIV with cnt <= L-1.
- MDIV: stall_n=0, c_dec_in <= bubble each edge; cnt decrements; go to RUN on the edge where cnt==1.
  - The opcode held in ID is ignored during MDIV.
- stall_n = 0 when in MDIV, or when in RUN with hz; 1 otherwise.
- bank_pending flag:
  - set on the edge issuing shr;
  - cleared on the edge issuing any other non-bubble word;
  - unchanged by bubbles.
- bank_en = bank_pending && opcode[3] && opcode[2:1] != 11 && state==RUN.
- busy = (state != RUN).
- Reset (asynchronous, rst=0):
  - state=RUN, cnt=0, c_dec_in=0, bank_pending=0.
  - Hence stall_n=1, flush_ir=0, busy=0, bank_en=0.
- Reset asserted mid-MDIV or mid-FLUSH aborts immediately; the first edge after release decodes normally.
- A taken-branch flush never overlaps a stall, because MDIV/FLUSH ignore the ID opcode.

Test Plan:
- add (0) with no hazard -> next edge c_dec_in=0x080; rr1_src=rr2_src=1; stall_n=1.
- ld in EX, ex_rd=3, ID add with id_rs2=3 -> stall_n=0 that cycle; next c_dec_in=0x000. Repeat with ex_rd=0 -> no stall.
- div with DIV_CYCLES=8 -> c_dec_in=0x096 (aluop 1011, reg wr) once, then stall_n=0 for exactly 7 cycles with bubbles, busy=1; then RUN. Reset asserted at stall cycle 3 -> stall_n=1, busy=0 at once.
- beq with B_taken=1 and FLUSH_SLOTS=3 -> pc_src=1, flush_ir=1, c_dec_in=0x01E; flush_ir stays 1 for 2 more cycles with bubbles. With B_taken=0 -> no flush.
- shr, then bubble, then adi -> bank_en=1 while adi is in ID; after adi issues, a following lui gives bank_en=0. shr then add then adi -> bank_en=0.
- jal with hz true in the same cycle -> hz wins: pc_src=0, flush_ir=0, stall_n=0.
